design_switcher: RTL

- Parametrised successor to the tapeout design multiplexer. Routes the shared chip pads `io_in`/`io_out` to one of `NUM_DES` user designs.
- Unlike the previous generation, it never hot-switches. A change of `des_sel` first isolates the pads, then holds the newly selected design in reset with zeroed inputs for `HOLD_CYCLES` cycles, and only then connects it.
- Sits between the pad ring/config scan chain and the design array.

---
 rtl/design_switcher.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/design_switcher.sv
// Routes the shared pads to one of NUM_DES user designs. Every selection change isolates the pads and
// holds the new design in reset for HOLD_CYCLES cycles. Optional macro DESIGN_SWITCHER_CLKEN_EN adds per-design clock enables.
module design_switcher #(
  parameter int NUM_DES     = 64,
  parameter int IO_W        = 12,
  parameter int SEL_W       = (NUM_DES > 1) ? $clog2(NUM_DES) : 1,
  parameter int HOLD_CYCLES = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IO_W-1:0]  io_in,
  output logic [IO_W-1:0]  io_out,
  input  logic [SEL_W-1:0] des_sel,
  input  logic             hold_if_not_sel,
  output logic [IO_W-1:0]  des_io_in  [NUM_DES],
  output logic             des_reset  [NUM_DES],
  input  logic [IO_W-1:0]  des_io_out [NUM_DES],
  output logic             busy,
  output logic [SEL_W-1:0] active_sel,
  output logic             sel_valid
`ifdef DESIGN_SWITCHER_CLKEN_EN
  ,
  output logic             des_clk_en [NUM_DES]
`endif
);

  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mm;
  logic             active;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_HOLD;
      cnt_q     <= CNT_INIT;
      sel_q     <= '0;
      cur_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  // Any pending mismatch restarts the isolate/hold sequence on the newest request.
  always_comb begin
    sel_d     = des_sel;
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    mm        = (sel_q != cur_sel_q);
    case (state_q)
      ST_ACTIVE: begin
        if (mm) begin
          state_d   = ST_ISOLATE;
          cur_sel_d = sel_q;
        end
      end
      ST_ISOLATE: begin
        state_d = ST_HOLD;
        cnt_d   = CNT_INIT;
        if (mm) cur_sel_d = sel_q;
      end
      ST_HOLD: begin
        if (mm) begin
          state_d   = ST_ISOLATE;
          cur_sel_d = sel_q;
        end else if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = CNT_INIT;
      end
    endcase
  end

  generate
    if (NUM_DES >= (1 << SEL_W)) begin : g_sel_full
      assign sel_valid = 1'b1;
    end else begin : g_sel_part
      localparam logic [SEL_W:0] NUM_DES_EXT = (SEL_W + 1)'(NUM_DES);
      assign sel_valid = ({1'b0, cur_sel_q} < NUM_DES_EXT);
    end
  endgenerate

  assign active     = (state_q == ST_ACTIVE);
  assign busy       = !active;
  assign active_sel = cur_sel_q;
  assign io_out     = (reset_n && active && sel_valid) ? des_io_out[cur_sel_q] : '0;

  always_comb begin
    for (int i = 0; i < NUM_DES; i++) begin
      des_io_in[i] = '0;
      des_reset[i] = 1'b1;
      if (reset_n) begin
        if (sel_valid && (cur_sel_q == SEL_W'(i))) begin
          if (active) begin
            des_io_in[i] = io_in;
            des_reset[i] = 1'b0;
          end
        end else if (!hold_if_not_sel) begin
          des_io_in[i] = io_in;
          des_reset[i] = 1'b0;
        end
      end
    end
  end

`ifdef DESIGN_SWITCHER_CLKEN_EN
  // The selected design keeps its clock through HOLD so the reset is actually clocked in.
  always_comb begin
    for (int i = 0; i < NUM_DES; i++) begin
      des_clk_en[i] = 1'b0;
      if (reset_n) begin
        if (sel_valid && (cur_sel_q == SEL_W'(i))) begin
          des_clk_en[i] = (state_q != ST_ISOLATE);
        end else begin
          des_clk_en[i] = !hold_if_not_sel;
        end
      end
    end
  end
`endif

endmodule
